// File: rtl/vga_txt_writer_if.sv
// Byte-stream handshake, clear request and text-buffer write port of the text writer.
interface vga_txt_writer_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [7:0]        i_d;
  logic              i_d_valid_h;
  logic              o_d_ready_h;
  logic              i_clr_h;
  logic              o_busy_h;
  logic [ADDR_W-1:0] o_addr_we;
  logic [7:0]        o_d_we;
  logic              o_we_en_h;
  logic [6:0]        o_cur_x;
  logic [4:0]        o_cur_y;

  modport master (
    output i_d, i_d_valid_h, i_clr_h,
    input  o_d_ready_h, o_busy_h, o_addr_we, o_d_we, o_we_en_h, o_cur_x, o_cur_y
  );

  modport slave (
    input  i_d, i_d_valid_h, i_clr_h,
    output o_d_ready_h, o_busy_h, o_addr_we, o_d_we, o_we_en_h, o_cur_x, o_cur_y
  );
endinterface

// File: rtl/vga_txt_writer.sv
// Write-side controller for the text video buffer: decodes a byte stream, tracks the
// cursor and performs full-screen and single-line clears one cell per clock.
module vga_txt_writer #(
  parameter int unsigned COLS     = 80,
  parameter int unsigned ROWS     = 30,
  parameter int unsigned ADDR_W   = 12,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input logic           i_clk,
  input logic           i_rst_h,
  vga_txt_writer_if.slave bus
);

  localparam int unsigned       CELLS     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [6:0]        LAST_X    = 7'(COLS - 1);
  localparam logic [4:0]        LAST_Y    = 5'(ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] row_base, row_base_nxt;
  logic              ready, ready_nxt;
  logic              busy, busy_nxt;
  logic              we_en, we_en_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [7:0]        data, data_nxt;
  logic [6:0]        cur_x, cur_x_nxt;
  logic [4:0]        cur_y, cur_y_nxt;

  logic              take;
  logic              nl_wrap;
  logic [4:0]        nl_y;
  logic [ADDR_W-1:0] nl_base;

  // ready is only ever high in IDLE, so it alone qualifies the handshake
  assign take    = ready && bus.i_d_valid_h && !bus.i_clr_h;
  assign nl_wrap = (cur_y == LAST_Y);
  assign nl_y    = nl_wrap ? 5'd0 : cur_y + 5'd1;
  assign nl_base = nl_wrap ? '0 : row_base + COLS_A;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst_h) begin
      state    <= CLR_ALL;
      cnt      <= '0;
      row_base <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      we_en    <= 1'b0;
      addr     <= '0;
      data     <= 8'h00;
      cur_x    <= 7'd0;
      cur_y    <= 5'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      row_base <= row_base_nxt;
      ready    <= ready_nxt;
      busy     <= busy_nxt;
      we_en    <= we_en_nxt;
      addr     <= addr_nxt;
      data     <= data_nxt;
      cur_x    <= cur_x_nxt;
      cur_y    <= cur_y_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      CLR_ALL:  if (cnt == LAST_CELL) state_nxt = IDLE;
      CLR_LINE: if (cnt == LAST_COL)  state_nxt = IDLE;
      IDLE: begin
        if (bus.i_clr_h) begin
          state_nxt = CLR_ALL;
        end else if (take) begin
          case (bus.i_d)
            CH_LF:        state_nxt = CLR_LINE;
            CH_FF:        state_nxt = CLR_ALL;
            CH_CR, CH_BS: state_nxt = IDLE;
            default:      if (cur_x == LAST_X) state_nxt = CLR_LINE;
          endcase
        end
      end
      default: state_nxt = CLR_ALL;
    endcase
  end

  // Next values of outputs, cursor and clear counter
  always_comb begin
    cnt_nxt      = cnt;
    row_base_nxt = row_base;
    cur_x_nxt    = cur_x;
    cur_y_nxt    = cur_y;
    ready_nxt    = 1'b0;
    busy_nxt     = 1'b0;
    we_en_nxt    = 1'b0;
    addr_nxt     = addr;
    data_nxt     = data;
    case (state)
      CLR_ALL: begin
        we_en_nxt    = 1'b1;
        addr_nxt     = cnt;
        data_nxt     = CLR_CHAR;
        busy_nxt     = 1'b1;
        cur_x_nxt    = 7'd0;
        cur_y_nxt    = 5'd0;
        row_base_nxt = '0;
        cnt_nxt      = (cnt == LAST_CELL) ? '0 : cnt + ADDR_W'(1);
      end
      CLR_LINE: begin
        we_en_nxt = 1'b1;
        addr_nxt  = row_base + cnt;
        data_nxt  = CLR_CHAR;
        busy_nxt  = 1'b1;
        cnt_nxt   = (cnt == LAST_COL) ? '0 : cnt + ADDR_W'(1);
      end
      IDLE: begin
        ready_nxt = 1'b1;
        if (bus.i_clr_h) begin
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else if (take) begin
          case (bus.i_d)
            CH_CR: cur_x_nxt = 7'd0;
            CH_LF: begin
              // first cell of the new row is cleared right away, CLR_LINE does the rest
              cur_x_nxt    = 7'd0;
              cur_y_nxt    = nl_y;
              row_base_nxt = nl_base;
              we_en_nxt    = 1'b1;
              addr_nxt     = nl_base;
              data_nxt     = CLR_CHAR;
              cnt_nxt      = ADDR_W'(1);
              ready_nxt    = 1'b0;
              busy_nxt     = 1'b1;
            end
            CH_BS: begin
              if (cur_x != 7'd0) begin
                cur_x_nxt = cur_x - 7'd1;
                we_en_nxt = 1'b1;
                addr_nxt  = row_base + ADDR_W'(cur_x - 7'd1);
                data_nxt  = CLR_CHAR;
              end
            end
            CH_FF: begin
              ready_nxt = 1'b0;
              busy_nxt  = 1'b1;
              cnt_nxt   = '0;
            end
            default: begin
              we_en_nxt = 1'b1;
              addr_nxt  = row_base + ADDR_W'(cur_x);
              data_nxt  = bus.i_d;
              if (cur_x == LAST_X) begin
                cur_x_nxt    = 7'd0;
                cur_y_nxt    = nl_y;
                row_base_nxt = nl_base;
                cnt_nxt      = '0;
                ready_nxt    = 1'b0;
                busy_nxt     = 1'b1;
              end else begin
                cur_x_nxt = cur_x + 7'd1;
              end
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  assign bus.o_d_ready_h = ready;
  assign bus.o_busy_h    = busy;
  assign bus.o_we_en_h   = we_en;
  assign bus.o_addr_we   = addr;
  assign bus.o_d_we      = data;
  assign bus.o_cur_x     = cur_x;
  assign bus.o_cur_y     = cur_y;

endmodule

// File: tb/tb_vga_txt_writer.sv
// Directed bench for vga_txt_writer: power-up clear, streaming, line wrap, control codes,
// clear request priority and reset in the middle of a clear.
module tb_vga_txt_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  vga_txt_writer_if #(.ADDR_W(12)) bus ();

  vga_txt_writer #(
    .COLS(80), .ROWS(30), .ADDR_W(12), .CLR_CHAR(8'h20)
  ) dut (
    .i_clk   (clk),
    .i_rst_h (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {we_en, addr, data}
  function automatic logic [31:0] wr_now();
    return 32'({bus.o_we_en_h, bus.o_addr_we, bus.o_d_we});
  endfunction

  function automatic logic [31:0] wr_exp(input logic en, input int a, input logic [7:0] d);
    return 32'({en, 12'(a), d});
  endfunction

  // {ready, busy, x, y}
  function automatic logic [31:0] st_now();
    return 32'({bus.o_d_ready_h, bus.o_busy_h, bus.o_cur_x, bus.o_cur_y});
  endfunction

  function automatic logic [31:0] st_exp(input logic r, input logic b, input int x, input int y);
    return 32'({r, b, 7'(x), 5'(y)});
  endfunction

  task automatic expect_clear(input string tag, input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, wr_now(), wr_exp(1'b1, start + i, 8'h20));
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.i_d = b;
    bus.i_d_valid_h = 1'b1;
    @(negedge clk);
    bus.i_d_valid_h = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.o_d_ready_h !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.o_d_ready_h), 32'd1);
  endtask

  initial begin
    bus.i_d = 8'h00;
    bus.i_d_valid_h = 1'b0;
    bus.i_clr_h = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_wr", wr_now(), wr_exp(1'b0, 0, 8'h00));
    chk("rst_st", st_now(), st_exp(1'b0, 1'b0, 0, 0));

    // power-up clear
    rst = 1'b0;
    expect_clear("pwr_clr", 0, 2400);
    chk("pwr_last_ready", st_now(), st_exp(1'b0, 1'b1, 0, 0));
    @(negedge clk);
    chk("pwr_done_st", st_now(), st_exp(1'b1, 1'b0, 0, 0));
    chk("pwr_done_we", 32'(bus.o_we_en_h), 32'd0);

    // back-to-back "AB"
    bus.i_d = 8'h41;
    bus.i_d_valid_h = 1'b1;
    @(negedge clk);
    chk("ab_a_wr", wr_now(), wr_exp(1'b1, 0, 8'h41));
    chk("ab_a_st", st_now(), st_exp(1'b1, 1'b0, 1, 0));
    bus.i_d = 8'h42;
    @(negedge clk);
    chk("ab_b_wr", wr_now(), wr_exp(1'b1, 1, 8'h42));
    chk("ab_b_st", st_now(), st_exp(1'b1, 1'b0, 2, 0));
    bus.i_d_valid_h = 1'b0;
    @(negedge clk);
    chk("ab_idle_we", 32'(bus.o_we_en_h), 32'd0);
    chk("ab_idle_st", st_now(), st_exp(1'b1, 1'b0, 2, 0));

    // CR: cursor to column 0, no write
    send(8'h0D);
    chk("cr_we", 32'(bus.o_we_en_h), 32'd0);
    chk("cr_st", st_now(), st_exp(1'b1, 1'b0, 0, 0));

    // 80 printable bytes fill row 0 and trigger a clear of row 1
    bus.i_d_valid_h = 1'b1;
    for (int i = 0; i < 80; i++) begin
      bus.i_d = 8'h30 + 8'(i % 10);
      @(negedge clk);
      chk("row0_wr", wr_now(), wr_exp(1'b1, i, 8'h30 + 8'(i % 10)));
      if (i < 79) chk("row0_ready", 32'(bus.o_d_ready_h), 32'd1);
    end
    bus.i_d_valid_h = 1'b0;
    chk("row0_end_st", st_now(), st_exp(1'b0, 1'b1, 0, 1));
    expect_clear("row1_clr", 80, 80);
    chk("row1_clr_last_ready", 32'(bus.o_d_ready_h), 32'd0);
    @(negedge clk);
    chk("row1_done_st", st_now(), st_exp(1'b1, 1'b0, 0, 1));

    // move down to row 29
    for (int r = 0; r < 28; r++) begin
      send(8'h0A);
      wait_ready("lf_walk_ready");
    end
    chk("at_row29_st", st_now(), st_exp(1'b1, 1'b0, 0, 29));

    // LF at the last row wraps to row 0
    send(8'h0A);
    chk("wrap_first_wr", wr_now(), wr_exp(1'b1, 0, 8'h20));
    chk("wrap_st", st_now(), st_exp(1'b0, 1'b1, 0, 0));
    expect_clear("wrap_clr", 1, 79);
    @(negedge clk);
    chk("wrap_done_st", st_now(), st_exp(1'b1, 1'b0, 0, 0));
    chk("wrap_done_we", 32'(bus.o_we_en_h), 32'd0);

    // BS and CR at column 0 do nothing
    send(8'h08);
    chk("bs0_we", 32'(bus.o_we_en_h), 32'd0);
    chk("bs0_st", st_now(), st_exp(1'b1, 1'b0, 0, 0));
    send(8'h0D);
    chk("cr0_we", 32'(bus.o_we_en_h), 32'd0);

    // cursor to (5,3), then BS
    for (int r = 0; r < 3; r++) begin
      send(8'h0A);
      wait_ready("lf_to3_ready");
    end
    for (int i = 0; i < 5; i++) begin
      send(8'h78);
      chk("row3_wr", wr_now(), wr_exp(1'b1, 240 + i, 8'h78));
    end
    chk("at_5_3_st", st_now(), st_exp(1'b1, 1'b0, 5, 3));
    send(8'h08);
    chk("bs_wr", wr_now(), wr_exp(1'b1, 244, 8'h20));
    chk("bs_st", st_now(), st_exp(1'b1, 1'b0, 4, 3));

    // clear request beats a simultaneous byte
    bus.i_clr_h = 1'b1;
    bus.i_d = 8'h55;
    bus.i_d_valid_h = 1'b1;
    @(negedge clk);
    bus.i_clr_h = 1'b0;
    bus.i_d_valid_h = 1'b0;
    chk("clrreq_we", 32'(bus.o_we_en_h), 32'd0);
    chk("clrreq_st", st_now(), st_exp(1'b0, 1'b1, 4, 3));
    expect_clear("clrreq_clr", 0, 2400);
    @(negedge clk);
    chk("clrreq_done_st", st_now(), st_exp(1'b1, 1'b0, 0, 0));

    // FF starts a full clear; reset at write #1000 restarts it
    send(8'h0C);
    chk("ff_st", st_now(), st_exp(1'b0, 1'b1, 0, 0));
    expect_clear("ff_clr", 0, 1000);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wr", wr_now(), wr_exp(1'b0, 0, 8'h00));
    chk("midrst_st", st_now(), st_exp(1'b0, 1'b0, 0, 0));
    rst = 1'b0;
    expect_clear("restart_clr", 0, 2400);
    @(negedge clk);
    chk("restart_done_st", st_now(), st_exp(1'b1, 1'b0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
